// File: rtl/llc_fifo_pkg.sv
// Shared types for the LLC FIFO family.
// Reader state doubles as the buffered-beat count (0..2).
package llc_fifo_pkg;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_ONE   = 2'd1,
    RD_FULL  = 2'd2
  } llc_fifo_rd_state_t;

endpackage

// File: rtl/llc_fifo_reader.sv
// Pop-side adapter for a non-fall-through LLC FIFO: head plus skid register give a
// registered valid/ready stream with no combinational path from out_ready_i to fifo_pop_o.
module llc_fifo_reader
  import llc_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter type dtype      = logic [DATA_WIDTH-1:0]
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       fifo_empty_i,
  input  dtype       fifo_data_i,
  output logic       fifo_pop_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output dtype       out_data_o,
  output logic [1:0] occupancy_o
);

  llc_fifo_rd_state_t occ_q, occ_d;
  dtype               head_q, head_d;
  dtype               skid_q, skid_d;
  logic               pop;
  logic               accept;

  always_comb begin
    // Pop depends only on registered occupancy, so ready never reaches the FIFO.
    pop    = ~fifo_empty_i & (occ_q != RD_FULL) & ~flush_i & ~rst_i;
    accept = (occ_q != RD_EMPTY) & out_ready_i;
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) begin
      occ_d = RD_EMPTY;
    end else begin
      case (occ_q)
        RD_EMPTY: begin
          if (pop) begin
            head_d = fifo_data_i;
            occ_d  = RD_ONE;
          end
        end
        RD_ONE: begin
          if (pop && accept) begin
            head_d = fifo_data_i;
          end else if (pop) begin
            skid_d = fifo_data_i;
            occ_d  = RD_FULL;
          end else if (accept) begin
            occ_d = RD_EMPTY;
          end
        end
        RD_FULL: begin
          if (accept) begin
            head_d = skid_q;
            occ_d  = RD_ONE;
          end
        end
        default: occ_d = RD_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q  <= RD_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign fifo_pop_o  = pop;
  assign out_valid_o = (occ_q != RD_EMPTY);
  assign out_data_o  = head_q;
  assign occupancy_o = occ_q;

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_empty_i |-> !fifo_pop_o);

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o)));

  a_occ_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    occ_q inside {RD_EMPTY, RD_ONE, RD_FULL});

endmodule
